// File: rtl/sram_bank_array_pkg.sv
// Shared constants and types for the tiled GF180 SRAM bank array.
// The read pipeline record remembers which port and row own the data arriving next cycle.
package sram_pkg;
  localparam int LANE_W    = 8;
  localparam int MACRO_AW  = 8;
  localparam int ROW_IDX_W = 8;  // enough row index for ADDR_W up to 16

  typedef enum logic {OWN_CORE = 1'b0, OWN_LOAD = 1'b1} owner_e;

  typedef struct packed {
    owner_e               owner;
    logic [ROW_IDX_W-1:0] row;
    logic                 valid;
  } rd_pipe_t;

  function automatic logic [LANE_W-1:0] lane_wen(input logic wr, input logic be);
    return (wr && be) ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
  endfunction
endpackage

// File: rtl/sram_bank_array_if.sv
// Request/response bundle for the core and loader ports of sram_bank_array.
// The requester drives master; the memory implements slave.
interface sram_bank_array_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  localparam int BE_W = DATA_W / 8;

  logic              load_mode;
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [BE_W-1:0]   c_be;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              l_req, l_we, l_gnt, l_rvalid;
  logic [BE_W-1:0]   l_be;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;

  modport master (
    output load_mode, c_req, c_we, c_be, c_addr, c_wdata, l_req, l_we, l_be, l_addr, l_wdata,
    input  c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata
  );
  modport slave (
    input  load_mode, c_req, c_we, c_be, c_addr, c_wdata, l_req, l_we, l_be, l_addr, l_wdata,
    output c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata
  );
endinterface

// File: rtl/gf180mcu_fd_ip_sram__sram256x8m8wm1.sv
// Behavioural model of the GF180 256x8 SRAM macro: active-low CEN/GWEN/WEN, registered Q.
// Q updates only on reads and holds its value across writes and idle cycles.
module gf180mcu_fd_ip_sram__sram256x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [7:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);
  logic [7:0] mem [256];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end
endmodule

// File: rtl/sram_bank_array_row.sv
// One row of byte-wide macros sharing CEN, GWEN and A, with per-lane WEN/D/Q.
module sram_row import sram_pkg::*; #(
  parameter int LANES = 2
) (
  input  logic                    clk,
  input  logic                    cen_i,
  input  logic                    gwen_i,
  input  logic [MACRO_AW-1:0]     a_i,
  input  logic [LANES*LANE_W-1:0] wen_i,
  input  logic [LANES*LANE_W-1:0] d_i,
  output logic [LANES*LANE_W-1:0] q_o
);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf180mcu_fd_ip_sram__sram256x8m8wm1 u_macro (
      .CLK  (clk),
      .CEN  (cen_i),
      .GWEN (gwen_i),
      .WEN  (wen_i[k*LANE_W +: LANE_W]),
      .A    (a_i),
      .D    (d_i[k*LANE_W +: LANE_W]),
      .Q    (q_o[k*LANE_W +: LANE_W])
    );
  end
endmodule

// File: rtl/sram_bank_array.sv
// Tiles 256x8 macros into a DATA_W x 2^ADDR_W memory shared by a core port and a loader port.
// Grants are combinational; read data returns one cycle later to the port that owned the read.
module sram_bank_array import sram_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int STARVE_LIM = 7,
  localparam int LANES = DATA_W / LANE_W,
  localparam int ROWS  = 1 << (ADDR_W - MACRO_AW)
) (
  input  logic                              clk,
  input  logic                              reset,
  sram_bank_array_if.slave                  bus,
  output logic [ROWS*LANES-1:0]             mac_cen_o,
  output logic [ROWS*LANES-1:0]             mac_gwen_o,
  output logic [ROWS*LANES*MACRO_AW-1:0]    mac_a_o,
  output logic [ROWS*LANES*LANE_W-1:0]      mac_wen_o,
  output logic [ROWS*LANES*LANE_W-1:0]      mac_d_o,
  output logic [ROWS*LANES*LANE_W-1:0]      mac_q_o
);
  logic [7:0]           starve_q, starve_d;
  rd_pipe_t             pipe_q, pipe_d;
  logic [DATA_W-1:0]    c_rdata_q, l_rdata_q;
  logic                 l_win, c_win, any_gnt, sel_we;
  logic [LANES-1:0]     sel_be;
  logic [15:0]          sel_addr;
  logic [DATA_W-1:0]    sel_wdata, pipe_rdata;
  logic [ROW_IDX_W-1:0] sel_row;
  logic [DATA_W-1:0]    row_q [ROWS];

  // Loader preempts the core in download mode, or once it has been denied STARVE_LIM cycles running.
  assign l_win   = reset && bus.l_req &&
                   (!bus.c_req || bus.load_mode || starve_q == 8'(STARVE_LIM));
  assign c_win   = reset && bus.c_req && !l_win;
  assign any_gnt = l_win || c_win;
  assign bus.l_gnt = l_win;
  assign bus.c_gnt = c_win;

  always_comb begin
    if (l_win) begin
      sel_we    = bus.l_we;
      sel_be    = bus.l_be;
      sel_addr  = 16'(bus.l_addr);
      sel_wdata = bus.l_wdata;
    end else begin
      sel_we    = bus.c_we;
      sel_be    = bus.c_be;
      sel_addr  = 16'(bus.c_addr);
      sel_wdata = bus.c_wdata;
    end
  end

  assign sel_row  = sel_addr[15:8];
  assign starve_d = (bus.l_req && !l_win) ? starve_q + 8'd1 : 8'd0;

  always_comb begin
    pipe_d       = '0;
    pipe_d.valid = any_gnt && !sel_we;
    pipe_d.owner = l_win ? OWN_LOAD : OWN_CORE;
    pipe_d.row   = sel_row;
  end

  always_comb begin
    pipe_rdata = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (pipe_q.row == ROW_IDX_W'(r)) pipe_rdata = row_q[r];
    end
  end

  // Each port's rdata follows the macro Q only while it owns the returning read, else holds.
  assign bus.c_rvalid = pipe_q.valid && (pipe_q.owner == OWN_CORE);
  assign bus.l_rvalid = pipe_q.valid && (pipe_q.owner == OWN_LOAD);
  assign bus.c_rdata  = bus.c_rvalid ? pipe_rdata : c_rdata_q;
  assign bus.l_rdata  = bus.l_rvalid ? pipe_rdata : l_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= 8'd0;
      pipe_q    <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pipe_q    <= pipe_d;
      c_rdata_q <= bus.c_rdata;
      l_rdata_q <= bus.l_rdata;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic              row_cen, row_gwen;
    logic [DATA_W-1:0] row_wen;

    assign row_cen  = !(any_gnt && sel_row == ROW_IDX_W'(r));
    assign row_gwen = !(any_gnt && sel_we);
    for (genvar k = 0; k < LANES; k++) begin : g_wen
      assign row_wen[k*LANE_W +: LANE_W] = lane_wen(any_gnt && sel_we, sel_be[k]);
      assign mac_a_o[(r*LANES+k)*MACRO_AW +: MACRO_AW] = sel_addr[MACRO_AW-1:0];
    end

    sram_row #(.LANES(LANES)) u_row (
      .clk    (clk),
      .cen_i  (row_cen),
      .gwen_i (row_gwen),
      .a_i    (sel_addr[MACRO_AW-1:0]),
      .wen_i  (row_wen),
      .d_i    (sel_wdata),
      .q_o    (row_q[r])
    );

    assign mac_cen_o[r*LANES +: LANES]   = {LANES{row_cen}};
    assign mac_gwen_o[r*LANES +: LANES]  = {LANES{row_gwen}};
    assign mac_wen_o[r*DATA_W +: DATA_W] = row_wen;
    assign mac_d_o[r*DATA_W +: DATA_W]   = sel_wdata;
    assign mac_q_o[r*DATA_W +: DATA_W]   = row_q[r];
  end
endmodule

// File: doc/sram_bank_array.md
# sram_bank_array

Parametrised memory subsystem that tiles 256x8 GF180 SRAM macros into a DATA_W x 2^ADDR_W word memory with two requesters: the processor core port and the IO-interface loader port. It generalises the fixed two-macro 16-bit instruction and data memories in user_project_wrapper by adding:
- configurable width and depth
- byte-lane write enables
- priority arbitration with a starvation guard
- a read-valid pipeline that tracks the one-cycle SRAM latency across banks

One instance serves as instruction memory and one as data memory.

## Interface
Parameters:
- DATA_W, 16, word width; multiple of 8, 8..64
- ADDR_W, 10, word address width; >= 8; rows = 2^(ADDR_W-8)
- STARVE_LIM, 7, consecutive denied load-port cycles before the load port is forced a grant; 1..255

Ports:
- clk  in  1  single clock for all logic and all macros
- reset  in  1  asynchronous, active-low
- load_mode  in  1  1 = loader has priority (program download); 0 = run
- c_req  in  1  core request
- c_we  in  1  core write (1) / read (0)
- c_be  in  DATA_W/8  core byte enables (writes only)
- c_addr  in  ADDR_W  core word address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- l_req, l_we, l_be, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata: loader port, same widths and meanings as the core port
- Macro-side buses, per row r and lane k: CEN, GWEN, WEN[7:0], A[7:0], D[7:0], Q[7:0], flattened as rows*lanes vectors

## Operation
- Macro pins are active-low:
  - CEN = 0 on the selected row only; all other rows idle with CEN = 1
  - GWEN = 0 on a write
  - WEN = 8'h00 for enabled lanes, 8'hFF for disabled lanes
- Row = addr[ADDR_W-1:8]; macro A = addr[7:0]; lane k carries data[8k+7:8k].
- Arbitration, combinational per cycle:
  - Only one port requests: that port wins.
  - Both request, load_mode = 1: loader wins.
  - Both request, load_mode = 0: core wins, unless starve_cnt == STARVE_LIM, in which case the loader wins.
  - The losing port sees gnt = 0 and must hold its request stable until granted.
- starve_cnt (8-bit):
  - Increments on each cycle l_req = 1 with l_gnt = 0.
  - Clears on l_gnt, or when l_req = 0.
- Read pipeline register, captured on each granted read:
  - Fields: owner (core/loader), row index, valid.
  - Next cycle, the owner's rvalid = 1 and its rdata = Q of the captured row, concatenated over lanes.
  - The non-owner's rdata holds its last value.
- Writes produce no rvalid. A write followed immediately by a read of the same address returns the new data (macro behaviour, no bypass needed).
- Reset mid-operation clears the pipeline register, so no rvalid is issued for a read granted before reset.

## Timing
- Reset values:
  - c_gnt = l_gnt = 0 (while reset is asserted)
  - c_rvalid = l_rvalid = 0
  - c_rdata = l_rdata = 0
  - starve_cnt = 0
  - all CEN = 1, all GWEN = 1, all WEN = 8'hFF
- gnt is combinational from req in the same cycle.
- Read latency: rvalid exactly 1 cycle after the granting edge.
- Throughput: one access per cycle total; back-to-back reads from alternating ports give alternating rvalid with no bubble.
- Simultaneous read grant and reset deassertion: the request is treated as granted and proceeds normally.
- load_mode changes take effect in the same cycle. A read in flight completes to its original owner.

## Structure
- Shared package sram_pkg:
  - LANE_W = 8 and MACRO_AW = 8
  - a typedef for the pipeline record {owner, row, valid}
  - an owner enum {OWN_CORE, OWN_LOAD}
- Sub-module sram_row: one row of DATA_W/8 gf180mcu_fd_ip_sram__sram256x8m8wm1 macros sharing CEN, GWEN and A, with per-lane WEN/D/Q. sram_bank_array generates rows x sram_row.
- The arbiter, starve counter and read pipeline live in the top module.

## Test plan
- Reset with c_req = 1: all outputs at reset values. After release, a core read of address 0x000 gives c_gnt in the same cycle and c_rvalid the next cycle.
- Loader writes 0xBEEF to 0x105 (row 1) and 0x1234 to 0x005 (row 0); core reads both -> c_rdata 0xBEEF then 0x1234 on consecutive cycles.
- Byte enables: write 0xAAAA to 0x010, then write 0x55FF with be = 2'b01 -> a read returns 0xAAFF.
- load_mode = 1 with both requesting: loader granted every cycle, c_gnt = 0. With load_mode = 0 and STARVE_LIM = 3: loader granted on every 4th cycle.
- Reset asserted the cycle after a granted read: no rvalid on either port, and rdata stays 0.
- DATA_W = 32, ADDR_W = 9: write 0xDEADBEEF to 0x1FF, read back; only row-1 CEN goes low.
